// File: rtl/mem_arbiter.sv
// Shares one main-memory line port between the I-fetch and D-access miss paths.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pipe_stall,
    output logic              timeout_err
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitrates I vs D
    // BUSY_I | I line read outstanding at memory
    // BUSY_D | D line read/write outstanding at memory
    // RESP   | ack pulse cycle; requests are not sampled
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state;
    logic [WDOG_W-1:0] wdogCnt;
    logic              grantD;
    logic              wdogExpired;

`ifdef MEMARB_RR_EN
    logic lastWasI;
    assign grantD = d_req & (~i_req | lastWasI);
`else
    assign grantD = d_req;
`endif

    // Counter sits at TIMEOUT-1 during the TIMEOUT-th BUSY cycle; expiry fires on that edge.
    assign wdogExpired = (TIMEOUT != 0) && (wdogCnt == WDOG_LAST);

    assign pipe_stall = (i_req & ~i_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wdogCnt     <= '0;
            i_ack       <= 1'b0;
            i_rdata     <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
`ifdef MEMARB_RR_EN
            lastWasI    <= 1'b1;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        mem_req <= 1'b1;
                        wdogCnt <= '0;
                        if (grantD) begin
                            state     <= BUSY_D;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= BUSY_I;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
`ifdef MEMARB_RR_EN
                        lastWasI <= ~grantD;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready || wdogExpired) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        // A completed write returns an all-zero line to the D side.
                        if (state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        end
                    end else begin
                        wdogCnt <= wdogCnt + WDOG_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter (TIMEOUT=4); honours MEMARB_RR_EN for the tie-break check.
module tb_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 32;
`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [LW-1:0] L1   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [LW-1:0] L2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LW-1:0] A5S  = {16{8'hA5}};
    localparam logic [LW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_ack, d_req, d_we, d_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ready, pipe_stall, timeout_err;

    int nVec  = 0;
    int nMiss = 0;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pipe_stall(pipe_stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold off nDelay cycles, then pulse mem_ready with data; returns in the ack cycle.
    task automatic serve(input int nDelay, input logic [LW-1:0] data);
        repeat (nDelay) tick();
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        doReset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_stall", pipe_stall, 0);

        // lone I read, ready on the 4th BUSY cycle (watchdog boundary, ready wins)
        i_req = 1; i_addr = 32'h100;
        #1 chk("t1_stall_req", pipe_stall, 1);
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        serve(3, L1);
        chk("t1_i_ack", i_ack, 1);
        chk("t1_i_rdata", i_rdata, L1);
        chk("t1_d_ack", d_ack, 0);
        chk("t1_mem_req_drop", mem_req, 0);
        chk("t1_tmo", timeout_err, 0);
        chk("t1_stall_ack", pipe_stall, 0);
        i_req = 0;
        tick();
        chk("t1_ack_pulse", i_ack, 0);
        chk("t1_rdata_hold", i_rdata, L1);

        // D read, then D write presented during the read's ack cycle
        d_req = 1; d_we = 0; d_addr = 32'h80;
        tick();
        chk("t2_rd_addr", mem_addr, 32'h80);
        chk("t2_rd_we", mem_we, 0);
        serve(0, L2);
        chk("t2_rd_ack", d_ack, 1);
        chk("t2_rd_data", d_rdata, L2);
        d_we = 1; d_addr = 32'h40; d_wdata = A5S;
        tick();
        chk("t2_resp_idle", mem_req, 0);
        tick();
        chk("t2_wr_req", mem_req, 1);
        chk("t2_wr_we", mem_we, 1);
        chk("t2_wr_addr", mem_addr, 32'h40);
        chk("t2_wr_wdata", mem_wdata, A5S);
        serve(1, L1);
        chk("t2_wr_ack", d_ack, 1);
        chk("t2_wr_rdata", d_rdata, 0);
        chk("t2_wr_we_drop", mem_we, 0);
        chk("t2_wr_i_ack", i_ack, 0);
        d_req = 0; d_we = 0;
        tick();
        chk("t2_ack_pulse", d_ack, 0);

        // simultaneous requests; D re-requests during its ack cycle
        doReset();
        i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h300;
        tick();
        chk("t3_first_d", mem_addr, 32'h300);
        serve(0, L2);
        chk("t3_d_ack", d_ack, 1);
        chk("t3_stall_i_wait", pipe_stall, 1);
        d_addr = 32'h340;
        tick();
        chk("t3_resp", mem_req, 0);
        tick();
        chk("t3_second_tie", mem_addr, RR ? 32'h200 : 32'h340);
        serve(0, L1);
        if (RR) begin
            chk("t3_tie_ack", i_ack, 1);
            i_req = 0;
        end else begin
            chk("t3_tie_ack", d_ack, 1);
            d_req = 0;
        end
        tick();
        tick();
        chk("t3_third", mem_addr, RR ? 32'h340 : 32'h200);
        serve(0, L2);
        chk("t3_last_ack", RR ? d_ack : i_ack, 1);
        i_req = 0; d_req = 0;
        tick();

        // back-to-back I with ready on first BUSY cycle
        i_req = 1; i_addr = 32'h500;
        #1 chk("t6_stall_req", pipe_stall, 1);
        tick();
        chk("t6_mem_req", mem_req, 1);
        chk("t6_addr", mem_addr, 32'h500);
        chk("t6_stall_busy", pipe_stall, 1);
        mem_ready = 1; mem_rdata = L2;
        tick();
        chk("t6_ack", i_ack, 1);
        chk("t6_rdata", i_rdata, L2);
        chk("t6_stall_ack", pipe_stall, 0);
        mem_ready = 0; mem_rdata = '0; i_addr = 32'h540;
        tick();
        chk("t6_idle_req", mem_req, 0);
        chk("t6_idle_ack", i_ack, 0);
        chk("t6_idle_stall", pipe_stall, 1);
        tick();
        chk("t6_next_req", mem_req, 1);
        chk("t6_next_addr", mem_addr, 32'h540);
        serve(0, L1);
        chk("t6_next_rdata", i_rdata, L1);
        i_req = 0;
        tick();

        // reset asserted mid BUSY_D
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = A5S;
        tick();
        chk("t5_busy", mem_req, 1);
        tick();
        #2 reset = 1;
        #1;
        chk("t5_async_req", mem_req, 0);
        chk("t5_async_we", mem_we, 0);
        chk("t5_no_ack", d_ack, 0);
        @(posedge clk);
        #1 reset = 0;
        chk("t5_rel_req", mem_req, 0);
        chk("t5_rel_ack", d_ack, 0);
        tick();
        chk("t5_reserve_req", mem_req, 1);
        chk("t5_reserve_addr", mem_addr, 32'h600);
        chk("t5_reserve_we", mem_we, 1);
        serve(0, L1);
        chk("t5_ack", d_ack, 1);
        chk("t5_rdata", d_rdata, 0);
        d_req = 0; d_we = 0;
        tick();

        // watchdog expiry, late ready in IDLE, sticky flag
        mem_rdata = ONES;
        i_req = 1; i_addr = 32'h700;
        tick();
        chk("t4_busy1", mem_req, 1);
        repeat (3) tick();
        chk("t4_busy4_req", mem_req, 1);
        chk("t4_busy4_ack", i_ack, 0);
        chk("t4_busy4_tmo", timeout_err, 0);
        tick();
        chk("t4_ack", i_ack, 1);
        chk("t4_rdata", i_rdata, 0);
        chk("t4_tmo", timeout_err, 1);
        chk("t4_req_drop", mem_req, 0);
        i_req = 0;
        tick();
        mem_ready = 1;
        tick();
        chk("t4_late_acks", {i_ack, d_ack}, 0);
        chk("t4_late_req", mem_req, 0);
        mem_ready = 0; mem_rdata = '0;
        d_req = 1; d_addr = 32'h800;
        tick();
        chk("t4_clean_req", mem_req, 1);
        serve(1, L2);
        chk("t4_clean_ack", d_ack, 1);
        chk("t4_clean_rdata", d_rdata, L2);
        chk("t4_sticky", timeout_err, 1);
        d_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
